// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C target receiver: address match, ACK generation, byte strobe
module i2c_target_rx #(
    parameter logic [6:0] OWN_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_rw,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_prev, sda_prev;
    logic       scl_rise, scl_fall, start, stop;
    logic [3:0] cnt;
    logic [7:0] shift;
    logic       match;

    // Synchronizers reset high so a released reset on an idle bus looks idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    assign start    = scl_s & sda_prev & ~sda_s;
    assign stop     = scl_s & ~sda_prev & sda_s;
    assign match    = (shift[7:1] == OWN_ADDR);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ADDR;
        end else if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                ADDR:     if (scl_fall && cnt == 4'd8) state_next = match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall) state_next = DATA;
                DATA:     if (scl_fall && cnt == 4'd8) state_next = DATA_ACK;
                DATA_ACK: if (scl_fall) state_next = DATA;
                default:  state_next = state;
            endcase
        end
    end

    always_comb begin
        sda_oe = 1'b0;
        if (state == ADDR_ACK || state == DATA_ACK) sda_oe = 1'b1;
    end

    // START/STOP override any bit activity in the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= 4'd0;
            shift      <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_rw      <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start) begin
                cnt        <= 4'd0;
                addr_match <= 1'b0;
                busy       <= 1'b1;
            end else if (stop) begin
                cnt        <= 4'd0;
                addr_match <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ADDR, DATA: begin
                        if (scl_rise && cnt < 4'd8) begin
                            shift <= {shift[6:0], sda_s};
                            cnt   <= cnt + 4'd1;
                            if (state == DATA && cnt == 4'd7) begin
                                rx_data  <= {shift[6:0], sda_s};
                                rx_valid <= 1'b1;
                            end
                        end
                        if (state == ADDR && scl_fall && cnt == 4'd8 && match)
                            rx_rw <= shift[0];
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            addr_match <= 1'b1;
                            cnt        <= 4'd0;
                        end
                    end
                    DATA_ACK: begin
                        if (scl_fall) cnt <= 4'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - randomized scoreboard bench for i2c_target_rx
module tb_i2c_target_rx;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rw;
    logic       addr_match;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         oe_cycles = 0;
    logic       in_ack = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] last_rx = 8'h00;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_rx #(.OWN_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_scl    (scl),
        .i2c_sda    (sda_bus),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_rw      (rx_rw),
        .addr_match (addr_match),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid strobe consumes one expected byte
    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected no strobe", rx_data);
            end else begin
                chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (sda_oe) begin
            oe_cycles++;
            if (scl) chk("oe_outside_ack", {31'h0, in_ack}, 32'd1);
        end
    end

    task automatic qw;
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; qw;
        scl = 1'b1;   qw;
        sda_m = 1'b0; qw;
        scl = 1'b0;   qw;
        chk("busy_after_start", {31'h0, busy}, 32'd1);
        chk("match_after_start", {31'h0, addr_match}, 32'd0);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; qw;
        scl = 1'b1;   qw;
        sda_m = 1'b1; qw; qw;
        chk("busy_after_stop", {31'h0, busy}, 32'd0);
        chk("match_after_stop", {31'h0, addr_match}, 32'd0);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qw;
        scl = 1'b1; qw; qw;
        scl = 1'b0; qw;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic ack;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; qw;
        in_ack = 1'b1;
        scl = 1'b1; qw;
        ack = ~sda_bus;
        qw;
        scl = 1'b0;
        in_ack = 1'b0;
        qw;
        chk(name, {31'h0, ack}, {31'h0, exp_ack});
    endtask

    // Model: only a matching address is ACKed; only complete data bytes after it are delivered
    task automatic transfer(input logic [6:0] addr, input logic rw, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int partial, input logic do_stop);
        logic       matched;
        logic [7:0] bytes[3];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        matched = (addr == 7'h50);
        i2c_start();
        send_byte({addr, rw}, matched, "addr_ack");
        chk("addr_match", {31'h0, addr_match}, {31'h0, matched});
        if (matched) chk("rx_rw", {31'h0, rx_rw}, {31'h0, rw});
        for (int i = 0; i < n; i++) begin
            if (matched) begin
                exp_q.push_back(bytes[i]);
                last_rx = bytes[i];
            end
            send_byte(bytes[i], matched, "data_ack");
        end
        for (int i = 0; i < partial; i++) send_bit(1'($urandom_range(0, 1)));
        if (do_stop) i2c_stop();
        if (partial > 0) chk("rx_hold", {24'h0, rx_data}, {24'h0, last_rx});
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("reset_outputs", {18'h0, sda_oe, rx_valid, rx_rw, addr_match, busy, rx_data}, 32'd0);
        reset = 1'b1;
        qw;

        transfer(7'h50, 1'b0, 1, 8'hAA, 8'h00, 8'h00, 0, 1'b1);
        oe_cycles = 0;
        transfer(7'h51, 1'b0, 1, 8'h55, 8'h00, 8'h00, 0, 1'b1);
        chk("nack_oe_cycles", oe_cycles, 32'd0);
        transfer(7'h50, 1'b1, 1, 8'h3C, 8'h00, 8'h00, 0, 1'b1);
        transfer(7'h50, 1'b0, 3, 8'h01, 8'h02, 8'h03, 0, 1'b1);
        transfer(7'h50, 1'b0, 0, 8'h00, 8'h00, 8'h00, 4, 1'b1);
        transfer(7'h50, 1'b0, 1, 8'h7E, 8'h00, 8'h00, 0, 1'b1);

        // Reset while the 5th address bit is on the bus, then recover
        i2c_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        sda_m = 1'b0; qw;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_reset_outputs", {18'h0, sda_oe, rx_valid, rx_rw, addr_match, busy, rx_data}, 32'd0);
        reset = 1'b1;
        last_rx = 8'h00;
        qw;
        scl = 1'b1; qw;
        sda_m = 1'b1; qw;
        chk("idle_after_reset", {31'h0, busy}, 32'd0);
        transfer(7'h50, 1'b0, 1, 8'hAA, 8'h00, 8'h00, 0, 1'b1);

        for (int r = 0; r < 25; r++) begin
            logic [6:0] a;
            int         n, part;
            logic       stp;
            a    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
            n    = $urandom_range(0, 3);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            stp  = (part > 0) || ($urandom_range(0, 2) != 0) || (r == 24);
            transfer(a, 1'($urandom_range(0, 1)), n, 8'($urandom), 8'($urandom), 8'($urandom),
                     part, stp);
        end

        qw; qw;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
